// File: rtl/ntt_pingpong_buffer_if.sv
// Host stream and NTT core memory-wrapper signals of the ping-pong coefficient buffer.
// slave is the buffer side; master is the host/core side.
interface ntt_pingpong_buffer_if #(
  parameter int LOGQ = 64,
  parameter int LOGN = 4
);
  localparam int AW = ((LOGN < 9) ? 9 : LOGN) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [LOGQ-1:0] in_data;
  logic            in_intt;
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] out_data;
  logic            out_last;
  logic            ntt_start;
  logic            ntt_intt;
  logic            ntt_finish;
  logic [AW-1:0]   ntt_read_address;
  logic [LOGQ-1:0] ntt_din;
  logic [AW-1:0]   ntt_write_address;
  logic            ntt_wea;
  logic [LOGQ-1:0] ntt_dout;

  modport slave (
    input  in_valid, in_data, in_intt, out_ready, ntt_finish,
           ntt_read_address, ntt_write_address, ntt_wea, ntt_dout,
    output in_ready, out_valid, out_data, out_last, ntt_start, ntt_intt, ntt_din
  );

  modport master (
    output in_valid, in_data, in_intt, out_ready, ntt_finish,
           ntt_read_address, ntt_write_address, ntt_wea, ntt_dout,
    input  in_ready, out_valid, out_data, out_last, ntt_start, ntt_intt, ntt_din
  );
endinterface

// File: rtl/ntt_pingpong_buffer.sv
// Two-bank ping-pong coefficient store: host loads one bank while the NTT core works on the other.
// Optional NTT_BUF_PERF_EN adds perf_cycles, the ntt_start-high cycle count of the last transform.
module ntt_pingpong_buffer #(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 4,
  parameter int DELAY_BRAM = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ntt_pingpong_buffer_if.slave bus,
  output logic                 err_addr
`ifdef NTT_BUF_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);
  localparam int N  = 2 ** LOGN;
  localparam int AW = ((LOGN < 9) ? 9 : LOGN) + 1;

  typedef enum logic [2:0] {FREE, LOAD, FULL, RUN, RESULT, DRAIN} bank_state_t;

  bank_state_t           state [2];
  logic                  ld_ptr, run_ptr, dr_ptr;
  logic [LOGN-1:0]       ld_cnt;
  logic [1:0]            bank_intt;
  logic                  start_q, intt_q, finish_q;
  logic [LOGN-1:0]       dr_addr;
  logic                  dr_issued_all;

  logic [LOGQ-1:0]       mem [2][N];
  logic [1:0]            wr_en;
  logic [1:0][LOGN-1:0]  wr_addr, rd_addr;
  logic [1:0][LOGQ-1:0]  wr_data, rd_q, dout;

  logic [DELAY_BRAM-1:0] pv, pl;
  logic [1:0]            inflight, fifo_cnt;
  logic [1:0][LOGQ-1:0]  fifo_data;
  logic [1:0]            fifo_last;
  logic                  fifo_wp, fifo_rp;

  logic in_ready_c, in_fire, run_active, launch, finish_rise;
  logic rd_hi_bad, wr_hi_bad, dr_issue, push, pop, out_valid_c;

  assign in_ready_c  = rst && (state[ld_ptr] == FREE || state[ld_ptr] == LOAD);
  assign in_fire     = bus.in_valid && in_ready_c;
  assign run_active  = (state[0] == RUN) || (state[1] == RUN);
  assign launch      = !run_active && (state[run_ptr] == FULL);
  assign finish_rise = bus.ntt_finish && !finish_q && (state[run_ptr] == RUN);
  assign rd_hi_bad   = |bus.ntt_read_address[AW-1:LOGN];
  assign wr_hi_bad   = |bus.ntt_write_address[AW-1:LOGN];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DELAY_BRAM; i++) inflight = inflight + 2'(pv[i]);
  end

  // Drain reads are throttled so FIFO entries plus reads in flight never exceed the 2-entry skid.
  assign dr_issue    = (state[dr_ptr] == DRAIN) && !dr_issued_all &&
                       (({1'b0, fifo_cnt} + {1'b0, inflight}) < 3'd2);
  assign push        = pv[DELAY_BRAM-1];
  assign out_valid_c = (fifo_cnt != 2'd0);
  assign pop         = out_valid_c && bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = fifo_data[fifo_rp];
  assign bus.out_last  = out_valid_c && fifo_last[fifo_rp];
  assign bus.ntt_start = start_q;
  assign bus.ntt_intt  = intt_q;
  assign bus.ntt_din   = (state[1] == RUN) ? dout[1] : dout[0];

  // Each bank's ports belong to the core while it runs, otherwise to the loader and drainer.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      wr_en[b]   = 1'b0;
      wr_addr[b] = ld_cnt;
      wr_data[b] = bus.in_data;
      rd_addr[b] = dr_addr;
      if (state[b] == RUN) begin
        wr_en[b]   = bus.ntt_wea && !wr_hi_bad;
        wr_addr[b] = bus.ntt_write_address[LOGN-1:0];
        wr_data[b] = bus.ntt_dout;
        rd_addr[b] = bus.ntt_read_address[LOGN-1:0];
      end else if (in_fire && (ld_ptr == 1'(b))) begin
        wr_en[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wr_en[b]) mem[b][wr_addr[b]] <= wr_data[b];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) rd_q[b] <= mem[b][rd_addr[b]];
    end
  end

  generate
    if (DELAY_BRAM == 2) begin : g_delay2
      logic [1:0][LOGQ-1:0] rd_q2;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_q2 <= '0;
        else      rd_q2 <= rd_q;
      end
      assign dout = rd_q2;
    end else begin : g_delay1
      assign dout = rd_q;
    end
  endgenerate

  // Bank lifecycle: each bank is touched by at most one of load/run/drain in any cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state[0]      <= FREE;
      state[1]      <= FREE;
      ld_ptr        <= 1'b0;
      run_ptr       <= 1'b0;
      dr_ptr        <= 1'b0;
      ld_cnt        <= '0;
      bank_intt     <= '0;
      start_q       <= 1'b0;
      intt_q        <= 1'b0;
      finish_q      <= 1'b0;
      dr_addr       <= '0;
      dr_issued_all <= 1'b0;
      err_addr      <= 1'b0;
    end else begin
      finish_q <= bus.ntt_finish;
      if (in_fire) begin
        if (ld_cnt == '0) begin
          state[ld_ptr]     <= LOAD;
          bank_intt[ld_ptr] <= bus.in_intt;
        end
        if (ld_cnt == {LOGN{1'b1}}) begin
          state[ld_ptr] <= FULL;
          ld_ptr        <= ~ld_ptr;
        end
        ld_cnt <= ld_cnt + 1'b1;
      end
      if (launch) begin
        state[run_ptr] <= RUN;
        start_q        <= 1'b1;
        intt_q         <= bank_intt[run_ptr];
      end else if (finish_rise) begin
        state[run_ptr] <= RESULT;
        run_ptr        <= ~run_ptr;
        start_q        <= 1'b0;
      end
      if (state[dr_ptr] == RESULT) begin
        state[dr_ptr] <= DRAIN;
        dr_addr       <= '0;
        dr_issued_all <= 1'b0;
      end
      if (dr_issue) begin
        dr_addr <= dr_addr + 1'b1;
        if (dr_addr == {LOGN{1'b1}}) dr_issued_all <= 1'b1;
      end
      if (pop && fifo_last[fifo_rp]) begin
        state[dr_ptr] <= FREE;
        dr_ptr        <= ~dr_ptr;
      end
      if (run_active && (rd_hi_bad || (bus.ntt_wea && wr_hi_bad))) err_addr <= 1'b1;
    end
  end

  // Read pipeline tags and the 2-entry output skid FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv        <= '0;
      pl        <= '0;
      fifo_data <= '0;
      fifo_last <= '0;
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      pv[0] <= dr_issue;
      pl[0] <= dr_issue && (dr_addr == {LOGN{1'b1}});
      for (int i = 1; i < DELAY_BRAM; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
      if (push) begin
        fifo_data[fifo_wp] <= dout[dr_ptr];
        fifo_last[fifo_wp] <= pl[DELAY_BRAM-1];
        fifo_wp            <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef NTT_BUF_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (launch)                          perf_cnt <= '0;
      else if (start_q && perf_cnt != '1)  perf_cnt <= perf_cnt + 1'b1;
      if (finish_rise) perf_cycles <= perf_cnt;
    end
  end
`endif

endmodule
